// File: rtl/player_lives_hud.sv
// Lives counter with post-death grace/blink window and a row of life icons for the VGA mux.
// Icon hits come from one fixed-position comparator per icon, so no divider is needed.

module player_life_icon #(
    parameter int X0     = 128,
    parameter int Y0     = 128,
    parameter int ICON_W = 32,
    parameter int ICON_H = 32
) (
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        hit
);
    // Interior only: the 1-pixel border ring of the icon is transparent.
    always_comb begin
        hit = (int'(pixelX) > X0) && (int'(pixelX) < X0 + ICON_W - 1) &&
              (int'(pixelY) > Y0) && (int'(pixelY) < Y0 + ICON_H - 1);
    end
endmodule

module player_lives_hud #(
    parameter int          MAX_LIVES    = 5,
    parameter int          INIT_LIVES   = 3,
    parameter int          ICON_W       = 32,
    parameter int          ICON_H       = 32,
    parameter int          ICON_GAP     = 4,
    parameter int          TOP_LEFT_X   = 128,
    parameter int          TOP_LEFT_Y   = 128,
    parameter int          GRACE_FRAMES = 60,
    parameter int          BLINK_HALF   = 8,
    parameter logic [11:0] LIFE_RGB     = 12'hF00
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               startOfFrame,
    input  logic                               player_died,
    input  logic                               extra_life,
    input  logic                               new_game,
    input  logic [10:0]                        pixelX,
    input  logic [10:0]                        pixelY,
    output logic                               player_life_dr,
    output logic [11:0]                        player_life_RGB,
    output logic [$clog2(MAX_LIVES+1)-1:0]     lives_count,
    output logic                               invuln,
    output logic                               no_lives
);
    localparam int LW = $clog2(MAX_LIVES + 1);
    localparam int GW = $clog2(GRACE_FRAMES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {ALIVE, GRACE, GAME_OVER} state_t;

    state_t          state, stateNext;
    logic [LW-1:0]   lives, livesNext, livesInc;
    logic [GW-1:0]   graceCnt, graceCntNext;
    logic [BW-1:0]   blinkCnt, blinkCntNext;
    logic            blinkPhase, blinkPhaseNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ALIVE;
            lives      <= LW'(INIT_LIVES);
            graceCnt   <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else begin
            state      <= stateNext;
            lives      <= livesNext;
            graceCnt   <= graceCntNext;
            blinkCnt   <= blinkCntNext;
            blinkPhase <= blinkPhaseNext;
        end
    end

    always_comb begin
        livesInc       = (lives == LW'(MAX_LIVES)) ? lives : lives + LW'(1);
        stateNext      = state;
        livesNext      = lives;
        graceCntNext   = graceCnt;
        blinkCntNext   = blinkCnt;
        blinkPhaseNext = blinkPhase;
        if (new_game) begin
            stateNext      = ALIVE;
            livesNext      = LW'(INIT_LIVES);
            graceCntNext   = '0;
            blinkCntNext   = '0;
            blinkPhaseNext = 1'b0;
        end else begin
            case (state)
                ALIVE: begin
                    if (player_died) begin
                        // A same-cycle extra life cancels the decrement.
                        livesNext = extra_life ? lives : lives - LW'(1);
                        if (lives > LW'(1)) begin
                            stateNext      = GRACE;
                            graceCntNext   = '0;
                            blinkCntNext   = '0;
                            blinkPhaseNext = 1'b1;
                        end else begin
                            stateNext = GAME_OVER;
                        end
                    end else if (extra_life) begin
                        livesNext = livesInc;
                    end
                end
                GRACE: begin
                    if (extra_life)
                        livesNext = livesInc;
                    if (startOfFrame) begin
                        if (graceCnt == GW'(GRACE_FRAMES - 1)) begin
                            stateNext      = ALIVE;
                            graceCntNext   = '0;
                            blinkCntNext   = '0;
                            blinkPhaseNext = 1'b0;
                        end else begin
                            graceCntNext = graceCnt + GW'(1);
                            if (blinkCnt == BW'(BLINK_HALF - 1)) begin
                                blinkCntNext   = '0;
                                blinkPhaseNext = ~blinkPhase;
                            end else begin
                                blinkCntNext = blinkCnt + BW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lives_count = lives;
        invuln      = (state == GRACE);
        no_lives    = (state == GAME_OVER);
    end

    logic [MAX_LIVES-1:0] iconHit, iconOn;
    logic                 drNext;

    for (genvar i = 0; i < MAX_LIVES; i++) begin : gIcon
        player_life_icon #(
            .X0    (TOP_LEFT_X + i * (ICON_W + ICON_GAP)),
            .Y0    (TOP_LEFT_Y),
            .ICON_W(ICON_W),
            .ICON_H(ICON_H)
        ) uIcon (
            .pixelX(pixelX),
            .pixelY(pixelY),
            .hit   (iconHit[i])
        );
        // The icon just lost stays visible on the blink-on half of grace.
        assign iconOn[i] = (i < int'(lives)) ||
                           ((state == GRACE) && blinkPhase && (i == int'(lives)));
    end

    assign drNext = |(iconHit & iconOn);

    always_ff @(posedge clk) begin
        if (reset) begin
            player_life_dr  <= 1'b0;
            player_life_RGB <= '0;
        end else begin
            player_life_dr  <= drNext;
            player_life_RGB <= drNext ? LIFE_RGB : 12'h000;
        end
    end
endmodule

// File: tb/tb_player_lives_hud.sv
// Bench for player_lives_hud: a frame-counting model checked every cycle, plus directed literals.

module tb_player_lives_hud;
    localparam int MAXL = 5, INITL = 3, W = 32, H = 32, GAP = 4;
    localparam int TLX = 128, TLY = 128, GRACEF = 60, BH = 8;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, player_died, extra_life, new_game;
    logic [10:0] pixelX, pixelY;
    logic        player_life_dr;
    logic [11:0] player_life_RGB;
    logic [2:0]  lives_count;
    logic        invuln, no_lives;

    always #5 clk = ~clk;

    player_lives_hud dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .player_died    (player_died),
        .extra_life     (extra_life),
        .new_game       (new_game),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .player_life_dr (player_life_dr),
        .player_life_RGB(player_life_RGB),
        .lives_count    (lives_count),
        .invuln         (invuln),
        .no_lives       (no_lives)
    );

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // st: 0 alive, 1 grace, 2 game over; frames = frames seen since grace began
    typedef struct packed {int lives; int st; int frames;} mdl_t;
    mdl_t m = '{lives: 0, st: 0, frames: 0};
    bit   mDr = 1'b0;

    function automatic mdl_t step(mdl_t c, bit rst, bit ng, bit died, bit xl, bit sof);
        mdl_t n = c;
        if (rst || ng) begin
            n.lives = INITL; n.st = 0; n.frames = 0;
            return n;
        end
        if (c.st == 2) return n;
        if (c.st == 0 && died) begin
            n.lives = c.lives - 1 + (xl ? 1 : 0);
            n.st = (c.lives == 1) ? 2 : 1;
            n.frames = 0;
            return n;
        end
        if (xl) n.lives = (c.lives < MAXL) ? c.lives + 1 : MAXL;
        if (c.st == 1 && sof) begin
            n.frames = c.frames + 1;
            if (n.frames == GRACEF) begin n.st = 0; n.frames = 0; end
        end
        return n;
    endfunction

    function automatic bit expDr(mdl_t c, int x, int y);
        int rel, i, off;
        rel = x - TLX;
        if (rel < 0) return 1'b0;
        i   = rel / (W + GAP);
        off = rel % (W + GAP);
        if (i >= MAXL) return 1'b0;
        if (off < 1 || off > W - 2) return 1'b0;
        if (y < TLY + 1 || y > TLY + H - 2) return 1'b0;
        if (i < c.lives) return 1'b1;
        return (c.st == 1) && ((c.frames / BH) % 2 == 0) && (i == c.lives);
    endfunction

    always @(posedge clk) begin
        mDr <= reset ? 1'b0 : expDr(m, int'(pixelX), int'(pixelY));
        m   <= step(m, reset, new_game, player_died, extra_life, startOfFrame);
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            chk("lives", int'(lives_count), m.lives);
            chk("invuln", int'(invuln), int'(m.st == 1));
            chk("no_lives", int'(no_lives), int'(m.st == 2));
            chk("dr", int'(player_life_dr), int'(mDr));
            chk("rgb", int'(player_life_RGB), mDr ? 32'hF00 : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(bit d, bit x, bit n, bit s);
        player_died = d; extra_life = x; new_game = n; startOfFrame = s;
        tick();
        player_died = 0; extra_life = 0; new_game = 0; startOfFrame = 0;
    endtask

    task automatic setPix(int x, int y);
        pixelX = 11'(x); pixelY = 11'(y);
        tick();
    endtask

    task automatic runGrace();
        for (int k = 0; k < GRACEF; k++) begin
            pulse(0, 0, 0, 1);
            tick();
        end
    endtask

    initial begin
        reset = 1; startOfFrame = 0; player_died = 0; extra_life = 0; new_game = 0;
        pixelX = 0; pixelY = 0;
        tick();
        checkEn = 1;
        tick();
        reset = 0;
        tick();
        chk("lit_reset_lives", int'(lives_count), 3);
        chk("lit_reset_nolives", int'(no_lives), 0);
        chk("lit_reset_invuln", int'(invuln), 0);

        setPix(129, 129);
        chk("lit_icon0_dr", int'(player_life_dr), 1);
        chk("lit_icon0_rgb", int'(player_life_RGB), 32'hF00);
        setPix(128, 128);
        chk("lit_border_dr", int'(player_life_dr), 0);

        pulse(1, 0, 0, 0);
        chk("lit_died_lives", int'(lives_count), 2);
        chk("lit_died_invuln", int'(invuln), 1);
        setPix(237, 140);
        chk("lit_icon3_dr", int'(player_life_dr), 0);
        setPix(201, 140);
        chk("lit_lost_icon_on", int'(player_life_dr), 1);
        pulse(1, 0, 0, 0);
        chk("lit_died_in_grace", int'(lives_count), 2);

        for (int k = 1; k <= GRACEF; k++) begin
            pulse(0, 0, 0, 1);
            tick();
            if (k == 8)  chk("lit_blink_off", int'(player_life_dr), 0);
            if (k == 16) chk("lit_blink_on", int'(player_life_dr), 1);
            if (k == 30) begin
                pulse(0, 1, 0, 0);
                chk("lit_extra_in_grace", int'(lives_count), 3);
            end
            if (k == GRACEF - 1) chk("lit_grace_last", int'(invuln), 1);
            if (k == GRACEF)     chk("lit_grace_end", int'(invuln), 0);
        end

        for (int k = 0; k < 5; k++) pulse(0, 1, 0, 0);
        chk("lit_saturate", int'(lives_count), 5);
        setPix(273, 140);
        chk("lit_icon4_dr", int'(player_life_dr), 1);

        for (int x = 120; x <= 320; x++) setPix(x, 129);
        for (int x = 120; x <= 320; x += 7) setPix(x, 158);
        setPix(131, 127); setPix(131, 128); setPix(131, 159); setPix(131, 160);
        setPix(307, 140); setPix(308, 140); setPix(309, 140);

        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        runGrace();
        pulse(1, 0, 0, 0);
        runGrace();
        chk("lit_one_left", int'(lives_count), 1);
        pulse(1, 0, 0, 0);
        chk("lit_over_lives", int'(lives_count), 0);
        chk("lit_over_flag", int'(no_lives), 1);
        chk("lit_over_invuln", int'(invuln), 0);
        setPix(129, 129);
        chk("lit_over_dr", int'(player_life_dr), 0);
        pulse(0, 1, 0, 0);
        chk("lit_over_extra", int'(lives_count), 0);
        pulse(0, 0, 1, 0);
        chk("lit_newgame_lives", int'(lives_count), 3);
        chk("lit_newgame_flag", int'(no_lives), 0);

        pulse(1, 1, 0, 0);
        chk("lit_died_extra_lives", int'(lives_count), 3);
        chk("lit_died_extra_invuln", int'(invuln), 1);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        setPix(129, 129);
        reset = 1;
        tick();
        chk("lit_rst_lives", int'(lives_count), 3);
        chk("lit_rst_invuln", int'(invuln), 0);
        chk("lit_rst_dr", int'(player_life_dr), 0);
        chk("lit_rst_rgb", int'(player_life_RGB), 0);
        reset = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
